// File: rtl/gray2bin_arbiter.sv
// gray2bin_arbiter: round-robin arbiter that feeds one shared gray2bin
// converter and returns the binary result on a valid/ready port, tagged with
// the requester index.
//
// Build option: define GRAY2BIN_ARB_FIXED_PRIO_EN for fixed priority (lowest
// index wins). Ports and timing are identical in both builds.

// Combinational Gray-to-binary converter. Each binary bit is the XOR of all
// Gray bits at or above it.
module gray2bin #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] binary
);

   genvar b;
   generate
      for (b = 0; b < WIDTH; b++) begin : g_bit
         assign binary[b] = ^gray[WIDTH-1:b];
      end
   endgenerate

endmodule

module gray2bin_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int IDX_WIDTH  = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_gray,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          out_valid,
   output logic [DATA_WIDTH-1:0]         out_binary,
   output logic [IDX_WIDTH-1:0]          out_src,
   input  logic                          out_ready
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      HOLD    = 2'd2
   } state_t;

   state_t                             state;
   logic [IDX_WIDTH-1:0]               rr_ptr;
   logic [DATA_WIDTH-1:0]              cap_gray;
   logic [IDX_WIDTH-1:0]               cap_idx;
   logic [DATA_WIDTH-1:0]              conv_bin;
   logic [NUM_REQ-1:0][DATA_WIDTH-1:0] gray_w;
   logic                               found;
   logic [IDX_WIDTH-1:0]               win;
   logic [IDX_WIDTH-1:0]               last_idx;

   assign gray_w   = req_gray;
   assign last_idx = IDX_WIDTH'(NUM_REQ - 1);

   // Winner search: first valid requester starting at rr_ptr, wrapping.
   // In the fixed-priority build rr_ptr stays 0, so this is lowest-index-wins.
   always_comb begin
      int idx;
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            win   = IDX_WIDTH'(idx);
         end
      end
   end

   // One-hot accept strobe, only offered while idle and out of reset.
   always_comb begin
      req_ready = '0;
      if (rst_n && state == IDLE && found) req_ready[win] = 1'b1;
   end

   gray2bin #(.WIDTH(DATA_WIDTH)) u_conv (
      .gray   (cap_gray),
      .binary (conv_bin)
   );

   // Sequencer: accept in IDLE, register converter output in CONVERT,
   // hold the result in HOLD until downstream takes it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         cap_gray   <= '0;
         cap_idx    <= '0;
         out_valid  <= 1'b0;
         out_binary <= '0;
         out_src    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  cap_gray <= gray_w[win];
                  cap_idx  <= win;
`ifdef GRAY2BIN_ARB_FIXED_PRIO_EN
                  rr_ptr   <= '0;
`else
                  rr_ptr   <= (win == last_idx) ? '0 : win + 1'b1;
`endif
                  state    <= CONVERT;
               end
            end
            CONVERT: begin
               out_binary <= conv_bin;
               out_src    <= cap_idx;
               out_valid  <= 1'b1;
               state      <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gray2bin_arbiter.sv
// Directed bench for gray2bin_arbiter (NUM_REQ=4, DATA_WIDTH=8, IDX_WIDTH=2).
// Compile with GRAY2BIN_ARB_FIXED_PRIO_EN to exercise the fixed-priority build.
module tb_gray2bin_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int IW = 2;

   logic             clk;
   logic             rst_n;
   logic [NR-1:0]    req_valid;
   logic [NR*DW-1:0] req_gray;
   logic [NR-1:0]    req_ready;
   logic             out_valid;
   logic [DW-1:0]    out_binary;
   logic [IW-1:0]    out_src;
   logic             out_ready;

   int n_cmp  = 0;
   int n_fail = 0;

   gray2bin_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_gray   (req_gray),
      .req_ready  (req_ready),
      .out_valid  (out_valid),
      .out_binary (out_binary),
      .out_src    (out_src),
      .out_ready  (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle away from the edge.
   task automatic nxt;
      @(posedge clk);
      #2;
   endtask

   initial begin
`ifndef GRAY2BIN_ARB_FIXED_PRIO_EN
      logic [7:0] rr_bin [4];
      rr_bin[0] = 8'h0A; rr_bin[1] = 8'hAA; rr_bin[2] = 8'h80; rr_bin[3] = 8'h01;
`endif
      // 1. reset with random inputs
      rst_n     = 1'b0;
      req_valid = NR'($urandom);
      req_gray  = $urandom;
      out_ready = 1'($urandom);
      #1 chk("rst_ready_comb", 32'(req_ready), 32'h0);
      nxt; nxt;
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_out_binary", 32'(out_binary), 32'h00);
      chk("rst_out_src", 32'(out_src), 32'h0);

      // 2. single request from req0
      rst_n     = 1'b1;
      out_ready = 1'b1;
      req_gray  = '0;
      req_gray[7:0] = 8'hC0;
      req_valid = 4'b0001;
      #1 chk("single_ready", 32'(req_ready), 32'h1);
      nxt;
      req_valid = 4'b0000;
      #1 chk("single_ready_convert", 32'(req_ready), 32'h0);
      chk("single_valid_convert", 32'(out_valid), 32'h0);
      nxt;
      chk("single_valid", 32'(out_valid), 32'h1);
      chk("single_binary", 32'(out_binary), 32'h80);
      chk("single_src", 32'(out_src), 32'h0);
      nxt;
      chk("single_valid_drop", 32'(out_valid), 32'h0);

`ifndef GRAY2BIN_ARB_FIXED_PRIO_EN
      // 3. round-robin across all four requesters
      rst_n = 1'b0;
      nxt;
      rst_n     = 1'b1;
      req_gray  = {8'h01, 8'hC0, 8'hFF, 8'h0F};
      req_valid = 4'hF;
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1 chk($sformatf("rr_ready_%0d", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
         nxt; nxt;
         chk($sformatf("rr_valid_%0d", k), 32'(out_valid), 32'h1);
         chk($sformatf("rr_src_%0d", k), 32'(out_src), 32'(k % 4));
         chk($sformatf("rr_binary_%0d", k), 32'(out_binary), 32'(rr_bin[k % 4]));
         nxt;
      end

      // 4. backpressure in HOLD (rr_ptr is now 1)
      out_ready = 1'b0;
      #1 chk("bp_ready_grant", 32'(req_ready), 32'h2);
      nxt; nxt;
      chk("bp_valid", 32'(out_valid), 32'h1);
      chk("bp_binary", 32'(out_binary), 32'hAA);
      chk("bp_src", 32'(out_src), 32'h1);
      for (int k = 0; k < 5; k++) begin
         nxt;
         chk($sformatf("bp_hold_valid_%0d", k), 32'(out_valid), 32'h1);
         chk($sformatf("bp_hold_binary_%0d", k), 32'(out_binary), 32'hAA);
         chk($sformatf("bp_hold_src_%0d", k), 32'(out_src), 32'h1);
         chk($sformatf("bp_hold_ready_%0d", k), 32'(req_ready), 32'h0);
      end
      out_ready = 1'b1;
      nxt;
      chk("bp_release_valid", 32'(out_valid), 32'h0);
      chk("bp_next_grant", 32'(req_ready), 32'h4);

      // 5. reset while in CONVERT (req2 accepted, rr_ptr would be 3)
      nxt;
      rst_n = 1'b0;
      nxt;
      chk("midrst_valid", 32'(out_valid), 32'h0);
      chk("midrst_ready", 32'(req_ready), 32'h0);
      rst_n     = 1'b1;
      req_valid = 4'b1010;
      #1 chk("midrst_ptr_zero", 32'(req_ready), 32'h2);
      nxt;
      req_valid = 4'b0000;
      #1 chk("midrst_convert_valid", 32'(out_valid), 32'h0);
      nxt;
      chk("midrst_out_valid", 32'(out_valid), 32'h1);
      chk("midrst_out_src", 32'(out_src), 32'h1);
      chk("midrst_out_binary", 32'(out_binary), 32'hAA);
      nxt;
      rst_n = 1'b0;
      nxt;
      rst_n     = 1'b1;
      req_valid = 4'b0111;
      #1 chk("midrst_req0_first", 32'(req_ready), 32'h1);
      req_valid = 4'b0100;
      #1 chk("midrst_req2_sole", 32'(req_ready), 32'h4);
      req_valid = 4'b0000;
`else
      // 6. fixed priority: req0 always beats req3
      rst_n = 1'b0;
      nxt;
      rst_n     = 1'b1;
      req_gray  = {8'h01, 8'h00, 8'h00, 8'hC0};
      req_valid = 4'b1001;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1 chk($sformatf("fp_ready_%0d", k), 32'(req_ready), 32'h1);
         nxt; nxt;
         chk($sformatf("fp_valid_%0d", k), 32'(out_valid), 32'h1);
         chk($sformatf("fp_src_%0d", k), 32'(out_src), 32'h0);
         chk($sformatf("fp_binary_%0d", k), 32'(out_binary), 32'h80);
         nxt;
      end
      req_valid = 4'b0000;
`endif

      nxt;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
